// File: rtl/mem_access_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stall_ctrl_if
// Description : MEM-stage request/response and stall-control bundle for
//               mem_access_stall_ctrl. Signal suffixes are relative to the
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_stall_ctrl_if #(
    parameter int ACC_W = 2
);
    logic             mem_read_i;
    logic             mem_write_i;
    logic             mem_resp_i;
    logic             ifetch_resp_i;
    logic [ACC_W-1:0] req_accesses_i;
    logic             req_last_write_i;
    logic             flush_i;
    logic             stall_pipeline_o;
    logic [ACC_W-1:0] access_idx_o;
    logic             last_write_o;
    logic             multi_access_o;
    logic [31:0]      stall_cycles_o;

    modport master (
        output mem_read_i, mem_write_i, mem_resp_i, ifetch_resp_i,
               req_accesses_i, req_last_write_i, flush_i,
        input  stall_pipeline_o, access_idx_o, last_write_o,
               multi_access_o, stall_cycles_o
    );

    modport slave (
        input  mem_read_i, mem_write_i, mem_resp_i, ifetch_resp_i,
               req_accesses_i, req_last_write_i, flush_i,
        output stall_pipeline_o, access_idx_o, last_write_o,
               multi_access_o, stall_cycles_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stall_ctrl
// Description : Pipeline stall controller for N-access memory instructions.
//               Optional macro STALL_PERF_EN enables the stall cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stall_ctrl #(
    parameter int MAX_ACCESSES = 2,
    parameter int ACC_W        = $clog2(MAX_ACCESSES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mem_access_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MULTI   = 2'd1,
        S_WAIT_IF = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] MAX_N = ACC_W'(MAX_ACCESSES);
    localparam logic [ACC_W-1:0] ONE   = ACC_W'(1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] idx_q, idx_d;
    logic [ACC_W-1:0] n_lat_q, n_lat_d;
    logic             wlast_q, wlast_d;
    logic             if_done_q, if_done_d;

    logic [ACC_W-1:0] n_eff;
    logic [ACC_W-1:0] last_idx;
    logic             mem_op;
    logic             stall_w;
    logic [ACC_W-1:0] acc_idx_w;
    logic             multi_w;
    logic             lw_w;

    assign mem_op   = bus.mem_read_i | bus.mem_write_i;
    assign last_idx = n_lat_q - ONE;

    always_comb begin
        n_eff = bus.req_accesses_i;
        if (bus.req_accesses_i == '0) begin
            n_eff = ONE;
        end else if (bus.req_accesses_i > MAX_N) begin
            n_eff = MAX_N;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            n_lat_q   <= '0;
            wlast_q   <= 1'b0;
            if_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            n_lat_q   <= n_lat_d;
            wlast_q   <= wlast_d;
            if_done_q <= if_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_lat_d   = n_lat_q;
        wlast_d   = wlast_q;
        if_done_d = if_done_q;
        stall_w   = 1'b0;
        acc_idx_w = '0;
        multi_w   = 1'b0;
        lw_w      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.flush_i) begin
                    stall_w   = !bus.ifetch_resp_i;
                    idx_d     = '0;
                    if_done_d = 1'b0;
                end else if (mem_op && (n_eff > ONE)) begin
                    // An early fetch must survive until the final access releases.
                    stall_w   = 1'b1;
                    if_done_d = if_done_q | bus.ifetch_resp_i;
                    if (bus.mem_resp_i) begin
                        n_lat_d = n_eff;
                        wlast_d = bus.req_last_write_i;
                        idx_d   = ONE;
                        state_d = S_MULTI;
                    end
                end else if (mem_op) begin
                    stall_w   = !bus.mem_resp_i || !bus.ifetch_resp_i;
                    if_done_d = 1'b0;
                end else begin
                    stall_w   = !bus.ifetch_resp_i;
                    if_done_d = 1'b0;
                end
            end
            S_MULTI: begin
                multi_w   = 1'b1;
                acc_idx_w = idx_q;
                lw_w      = wlast_q && (idx_q == last_idx);
                stall_w   = 1'b1;
                if (bus.flush_i) begin
                    stall_w   = !bus.ifetch_resp_i;
                    state_d   = S_IDLE;
                    idx_d     = '0;
                    if_done_d = 1'b0;
                end else if (bus.mem_resp_i && (idx_q < last_idx)) begin
                    idx_d     = idx_q + ONE;
                    if_done_d = if_done_q | bus.ifetch_resp_i;
                end else if (bus.mem_resp_i) begin
                    idx_d     = '0;
                    if_done_d = 1'b0;
                    if (if_done_q || bus.ifetch_resp_i) begin
                        stall_w = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_IF;
                    end
                end else begin
                    if_done_d = if_done_q | bus.ifetch_resp_i;
                end
            end
            S_WAIT_IF: begin
                stall_w   = !bus.ifetch_resp_i;
                if_done_d = 1'b0;
                if (bus.ifetch_resp_i || bus.flush_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                idx_d     = '0;
                if_done_d = 1'b0;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted, including mid-sequence.
    assign bus.stall_pipeline_o = rst_n & stall_w;
    assign bus.access_idx_o     = rst_n ? acc_idx_w : '0;
    assign bus.multi_access_o   = rst_n & multi_w;
    assign bus.last_write_o     = rst_n & lw_w;

`ifdef STALL_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_w && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cycles_o = stall_cnt_q;
`else
    assign bus.stall_cycles_o = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stall_ctrl
// Description : Self-checking bench for mem_access_stall_ctrl (MAX_ACCESSES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stall_ctrl;

    localparam int MAX = 4;
    localparam int AW  = $clog2(MAX + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mem_access_stall_ctrl_if #(.ACC_W(AW)) bus ();

    mem_access_stall_ctrl #(
        .MAX_ACCESSES(MAX),
        .ACC_W       (AW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level reference: counts completed data accesses of the
    // current multi-access op rather than tracking controller states.
    int     m_done;
    int     m_n;
    bit     m_wl;
    bit     m_seen;
    bit     m_wait;
    longint m_cnt;

    bit a_stall, a_multi, a_lw;
    int a_idx;
    int obs_stalls, obs_multi;

    typedef struct {
        bit rd, wr, resp, ifr;
        int req;
        bit lw, fl;
        bit e_stall;
        int e_idx;
        bit e_multi, e_lw;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int neff(input int r);
        if (r == 0) return 1;
        if (r > MAX) return MAX;
        return r;
    endfunction

    task automatic model_eval(output bit s, output int ix, output bit mu, output bit lw);
        bit op;
        int n;
        op = bus.mem_read_i | bus.mem_write_i;
        n  = neff(int'(bus.req_accesses_i));
        s = 1'b0; ix = 0; mu = 1'b0; lw = 1'b0;
        if (m_wait) begin
            s = !bus.ifetch_resp_i;
        end else if (m_done > 0) begin
            mu = 1'b1;
            ix = m_done;
            lw = m_wl && (m_done == m_n - 1);
            if (bus.flush_i)
                s = !bus.ifetch_resp_i;
            else
                s = !(bus.mem_resp_i && (m_done == m_n - 1) && (m_seen || bus.ifetch_resp_i));
        end else begin
            if (bus.flush_i)       s = !bus.ifetch_resp_i;
            else if (op && n > 1)  s = 1'b1;
            else if (op)           s = !(bus.mem_resp_i && bus.ifetch_resp_i);
            else                   s = !bus.ifetch_resp_i;
        end
    endtask

    task automatic model_update(input bit s);
        bit op;
        bit seen_now;
        int n;
        op       = bus.mem_read_i | bus.mem_write_i;
        n        = neff(int'(bus.req_accesses_i));
        seen_now = m_seen | bus.ifetch_resp_i;
        if (s && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (m_wait) begin
            if (bus.ifetch_resp_i || bus.flush_i) m_wait = 1'b0;
            m_seen = 1'b0;
        end else if (m_done > 0) begin
            if (bus.flush_i) begin
                m_done = 0;
                m_seen = 1'b0;
            end else if (bus.mem_resp_i) begin
                m_done++;
                if (m_done == m_n) begin
                    m_done = 0;
                    m_wait = !seen_now;
                    m_seen = 1'b0;
                end else begin
                    m_seen = seen_now;
                end
            end else begin
                m_seen = seen_now;
            end
        end else begin
            if (!bus.flush_i && op && n > 1) begin
                m_seen = seen_now;
                if (bus.mem_resp_i) begin
                    m_done = 1;
                    m_n    = n;
                    m_wl   = bus.req_last_write_i;
                end
            end else begin
                m_seen = 1'b0;
            end
        end
    endtask

    task automatic drive(input bit rd, wr, resp, ifr, input int req, input bit lw, fl);
        bus.mem_read_i       = rd;
        bus.mem_write_i      = wr;
        bus.mem_resp_i       = resp;
        bus.ifetch_resp_i    = ifr;
        bus.req_accesses_i   = AW'(req);
        bus.req_last_write_i = lw;
        bus.flush_i          = fl;
    endtask

    task automatic cyc(input bit rd, wr, resp, ifr, input int req, input bit lw, fl);
        bit e_s, e_mu, e_lw;
        int e_ix;
        longint e_cnt;
        drive(rd, wr, resp, ifr, req, lw, fl);
        @(negedge clk);
        model_eval(e_s, e_ix, e_mu, e_lw);
`ifdef STALL_PERF_EN
        e_cnt = m_cnt;
`else
        e_cnt = 0;
`endif
        a_stall = bus.stall_pipeline_o;
        a_idx   = int'(bus.access_idx_o);
        a_multi = bus.multi_access_o;
        a_lw    = bus.last_write_o;
        if (a_stall) obs_stalls++;
        if (a_multi) obs_multi++;
        chk("model_stall", 32'(a_stall), 32'(e_s));
        chk("model_idx",   32'(a_idx),   32'(e_ix));
        chk("model_multi", 32'(a_multi), 32'(e_mu));
        chk("model_lw",    32'(a_lw),    32'(e_lw));
        chk("model_cnt",   bus.stall_cycles_o, 32'(e_cnt));
        @(posedge clk);
        model_update(e_s);
        #1;
    endtask

    // Asynchronous reset applied away from the clock edge; outputs must drop at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_stall", 32'(bus.stall_pipeline_o), 32'd0);
        chk("rst_idx",   32'(bus.access_idx_o),     32'd0);
        chk("rst_multi", 32'(bus.multi_access_o),   32'd0);
        chk("rst_lw",    32'(bus.last_write_o),     32'd0);
        chk("rst_cnt",   bus.stall_cycles_o,        32'd0);
        drive(0, 0, 0, 0, 1, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        m_done = 0; m_n = 0; m_wl = 1'b0; m_seen = 1'b0; m_wait = 1'b0; m_cnt = 0;
        obs_stalls = 0; obs_multi = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //         rd wr rs if req lw fl  st ix mu lw
        vt[0] = '{1, 0, 1, 1, 1, 0, 0,  0, 0, 0, 0};
        vt[1] = '{1, 0, 1, 0, 1, 0, 0,  1, 0, 0, 0};
        vt[2] = '{1, 0, 0, 1, 1, 0, 0,  1, 0, 0, 0};
        vt[3] = '{0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0};
        vt[4] = '{0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0};
        vt[5] = '{0, 1, 1, 1, 2, 1, 0,  1, 0, 0, 0};
        vt[6] = '{1, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0};
        vt[7] = '{1, 0, 1, 1, 7, 0, 0,  1, 0, 0, 0};
        vt[8] = '{1, 0, 0, 1, 1, 0, 1,  0, 0, 0, 0};
        vt[9] = '{0, 1, 1, 0, 3, 0, 1,  1, 0, 0, 0};

        drive(0, 0, 0, 0, 1, 0, 0);
        #1;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            do_reset();
            drive(vt[i].rd, vt[i].wr, vt[i].resp, vt[i].ifr, vt[i].req, vt[i].lw, vt[i].fl);
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), 32'(bus.stall_pipeline_o), 32'(vt[i].e_stall));
            chk($sformatf("vec%0d_idx", i),   32'(bus.access_idx_o),     32'(vt[i].e_idx));
            chk($sformatf("vec%0d_multi", i), 32'(bus.multi_access_o),   32'(vt[i].e_multi));
            chk($sformatf("vec%0d_lw", i),    32'(bus.last_write_o),     32'(vt[i].e_lw));
            @(posedge clk);
            #1;
        end

        // LDI-type n=2: fetch arrives early, first access 4 cycles, second 3 cycles.
        do_reset();
        cyc(1, 0, 0, 0, 2, 0, 0);
        cyc(1, 0, 0, 1, 2, 0, 0);
        cyc(1, 0, 0, 0, 2, 0, 0);
        cyc(1, 0, 1, 0, 2, 0, 0);
        cyc(0, 0, 0, 0, 2, 0, 0);
        cyc(0, 0, 0, 0, 2, 0, 0);
        cyc(0, 0, 1, 0, 2, 0, 0);
        chk("ldi_release_stall", 32'(a_stall), 32'd0);
        chk("ldi_stall_total",   32'(obs_stalls), 32'd6);
        chk("ldi_multi_total",   32'(obs_multi),  32'd3);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk("ldi_after_idle", 32'(a_stall), 32'd0);

        // STI-type n=4: index walks 0..3, last_write only on the final access.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 1, (k == 3), 4, 1, 0);
            chk($sformatf("sti_idx%0d", k), 32'(a_idx), 32'(k));
            chk($sformatf("sti_lw%0d", k),  32'(a_lw),  32'(k == 3));
        end
        chk("sti_release", 32'(a_stall), 32'd0);

        // Final access completes before the fetch: held until ifetch_resp.
        do_reset();
        cyc(1, 0, 1, 0, 2, 0, 0);
        cyc(0, 0, 1, 0, 2, 0, 0);
        chk("wif_final_stall", 32'(a_stall), 32'd1);
        cyc(0, 0, 0, 0, 2, 0, 0);
        chk("wif_hold_stall", 32'(a_stall), 32'd1);
        chk("wif_hold_multi", 32'(a_multi), 32'd0);
        cyc(0, 0, 0, 1, 2, 0, 0);
        chk("wif_drop_stall", 32'(a_stall), 32'd0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk("wif_idle", 32'(a_stall), 32'd0);

        // Flush wins over mem_resp at idx1 of n=3.
        do_reset();
        cyc(1, 0, 1, 0, 3, 0, 0);
        cyc(0, 0, 1, 0, 3, 0, 1);
        chk("flush_cycle_idx", 32'(a_idx), 32'd1);
        cyc(0, 0, 0, 1, 3, 0, 0);
        chk("flush_after_idx",   32'(a_idx),   32'd0);
        chk("flush_after_multi", 32'(a_multi), 32'd0);
        chk("flush_after_stall", 32'(a_stall), 32'd0);

        // Reset mid-sequence, then ten stall cycles for the counter.
        cyc(1, 0, 1, 0, 3, 0, 0);
        cyc(1, 0, 0, 0, 3, 0, 0);
        drive(1, 0, 0, 0, 3, 0, 0);
        do_reset();
        for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
`ifdef STALL_PERF_EN
        chk("perf_cnt10", bus.stall_cycles_o, 32'd10);
`else
        chk("perf_cnt_off", bus.stall_cycles_o, 32'd0);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 4) < 2,
                int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                $urandom_range(0, 19) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
